// File: rtl/pacman_game_pkg.sv
// Shared types and constants for the Pacman game flow controller.
package pacman_game_pkg;

  localparam int unsigned FRAME_CNT_W = 8;
  localparam int unsigned SCREEN_W    = 2;
  localparam int unsigned LIVES_W     = 3;
  localparam int unsigned LEVEL_W     = 4;

  // PAUSED is always present so the encoding does not depend on the build.
  typedef enum logic [2:0] {
    ST_TITLE      = 3'd0,
    ST_READY      = 3'd1,
    ST_PLAY       = 3'd2,
    ST_DYING      = 3'd3,
    ST_LEVEL_DONE = 3'd4,
    ST_GAME_OVER  = 3'd5,
    ST_PAUSED     = 3'd6
  } game_state_t;

  localparam logic [SCREEN_W-1:0] SCREEN_TITLE = 2'd0;
  localparam logic [SCREEN_W-1:0] SCREEN_MAZE  = 2'd1;
  localparam logic [SCREEN_W-1:0] SCREEN_OVER  = 2'd2;

  // Screen renderer select for a given game state.
  function automatic logic [SCREEN_W-1:0] screen_of(game_state_t s);
    case (s)
      ST_TITLE:     screen_of = SCREEN_TITLE;
      ST_GAME_OVER: screen_of = SCREEN_OVER;
      default:      screen_of = SCREEN_MAZE;
    endcase
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Player/gameplay inputs and game-control outputs of the flow controller.
interface game_flow_ctrl_if;
  import pacman_game_pkg::*;

  logic                frame_tick_i;
  logic                start_btn_i;
  logic                death_i;
  logic                dots_cleared_i;
  logic [SCREEN_W-1:0] screen_o;
  logic                game_run_o;
  logic [LIVES_W-1:0]  lives_o;
  logic [LEVEL_W-1:0]  level_o;
  logic                restart_o;
  logic                new_level_o;

  modport master (
    output frame_tick_i, start_btn_i, death_i, dots_cleared_i,
    input  screen_o, game_run_o, lives_o, level_o, restart_o, new_level_o
  );

  modport slave (
    input  frame_tick_i, start_btn_i, death_i, dots_cleared_i,
    output screen_o, game_run_o, lives_o, level_o, restart_o, new_level_o
  );
endinterface

// File: rtl/game_flow_ctrl_start_btn_sync.sv
// Start button synchronizer (two flops) with rising-edge detect.
module start_btn_sync (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic btn_i,
  output logic start_edge_c
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign start_edge_c = sync2_q & ~prev_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Pacman game sequencer: title, ready, play, dying, level-done, game-over.
// Optional PAUSED state when GAME_PAUSE_EN is defined.
module game_flow_ctrl
  import pacman_game_pkg::*;
#(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned MAX_LEVEL      = 15,
  parameter int unsigned READY_FRAMES   = 120,
  parameter int unsigned DYING_FRAMES   = 90,
  parameter int unsigned LEVEL_FRAMES   = 60,
  parameter int unsigned GO_HOLD_FRAMES = 180
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  game_flow_ctrl_if.slave bus
);

  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = LEVEL_W'(MAX_LEVEL);
  localparam logic [LEVEL_W-1:0] LEVEL_ONE = LEVEL_W'(1);

  logic start_edge_c;

  game_state_t            state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
  logic [LIVES_W-1:0]     lives_q, lives_d;
  logic [LEVEL_W-1:0]     level_q, level_d;
  logic                   restart_q, restart_d;
  logic                   new_level_q, new_level_d;
  logic [SCREEN_W-1:0]    screen_q, screen_d;
  logic                   run_q, run_d;

  start_btn_sync u_start_sync (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .btn_i        (bus.start_btn_i),
    .start_edge_c (start_edge_c)
  );

  // State, counters and all registered outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= ST_TITLE;
      cnt_q       <= '0;
      lives_q     <= LIVES_RST;
      level_q     <= LEVEL_ONE;
      restart_q   <= 1'b0;
      new_level_q <= 1'b0;
      screen_q    <= SCREEN_TITLE;
      run_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      restart_q   <= restart_d;
      new_level_q <= new_level_d;
      screen_q    <= screen_d;
      run_q       <= run_d;
    end
  end

  // Next-state, lives/level update, pulses and frame counter.
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    level_d     = level_q;
    restart_d   = 1'b0;
    new_level_d = 1'b0;
    cnt_d       = cnt_q;

    case (state_q)
      ST_TITLE: begin
        if (start_edge_c) begin
          state_d     = ST_READY;
          lives_d     = LIVES_RST;
          level_d     = LEVEL_ONE;
          restart_d   = 1'b1;
          new_level_d = 1'b1;
        end
      end
      ST_READY: begin
        if (bus.frame_tick_i && cnt_q == FRAME_CNT_W'(READY_FRAMES - 1)) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // A simultaneous death is dropped in favour of the level clear.
        if (bus.dots_cleared_i) begin
          state_d = ST_LEVEL_DONE;
        end else if (bus.death_i) begin
          state_d = ST_DYING;
`ifdef GAME_PAUSE_EN
        end else if (start_edge_c) begin
          state_d = ST_PAUSED;
`endif
        end
      end
      ST_DYING: begin
        if (bus.frame_tick_i && cnt_q == FRAME_CNT_W'(DYING_FRAMES - 1)) begin
          if (lives_q == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = ST_GAME_OVER;
          end else begin
            lives_d   = lives_q - LIVES_W'(1);
            restart_d = 1'b1;
            state_d   = ST_READY;
          end
        end
      end
      ST_LEVEL_DONE: begin
        if (bus.frame_tick_i && cnt_q == FRAME_CNT_W'(LEVEL_FRAMES - 1)) begin
          level_d     = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + LEVEL_W'(1);
          restart_d   = 1'b1;
          new_level_d = 1'b1;
          state_d     = ST_READY;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge_c && cnt_q >= FRAME_CNT_W'(GO_HOLD_FRAMES - 1)) begin
          state_d = ST_TITLE;
        end
      end
      ST_PAUSED: begin
`ifdef GAME_PAUSE_EN
        if (start_edge_c) begin
          state_d = ST_PLAY;
        end
`else
        state_d = ST_TITLE;
`endif
      end
      default: state_d = ST_TITLE;
    endcase

    // Saturating frame counter, restarted on every state change.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (bus.frame_tick_i && state_q != ST_PAUSED && cnt_q != '1) begin
      cnt_d = cnt_q + FRAME_CNT_W'(1);
    end

    screen_d = screen_of(state_d);
    run_d    = (state_d == ST_PLAY);
  end

  assign bus.screen_o    = screen_q;
  assign bus.game_run_o  = run_q;
  assign bus.lives_o     = lives_q;
  assign bus.level_o     = level_q;
  assign bus.restart_o   = restart_q;
  assign bus.new_level_o = new_level_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed self-checking bench for game_flow_ctrl.
module tb_game_flow_ctrl;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  game_flow_ctrl_if bus ();

  game_flow_ctrl dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // All tasks start and end at a falling edge.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      bus.frame_tick_i = 1'b1;
      @(negedge clk);
    end
    bus.frame_tick_i = 1'b0;
  endtask

  task automatic pulse_death();
    bus.death_i = 1'b1;
    @(negedge clk);
    bus.death_i = 1'b0;
  endtask

  task automatic pulse_dots();
    bus.dots_cleared_i = 1'b1;
    @(negedge clk);
    bus.dots_cleared_i = 1'b0;
  endtask

  task automatic press();
    bus.start_btn_i = 1'b1;
    cycles(4);
    bus.start_btn_i = 1'b0;
    cycles(3);
  endtask

  initial begin
    bus.frame_tick_i   = 1'b0;
    bus.start_btn_i    = 1'b0;
    bus.death_i        = 1'b0;
    bus.dots_cleared_i = 1'b0;
    reset_n            = 1'b0;
    cycles(3);
    chk("rst_screen", 32'(bus.screen_o), 0);
    chk("rst_run", 32'(bus.game_run_o), 0);
    chk("rst_lives", 32'(bus.lives_o), 3);
    chk("rst_level", 32'(bus.level_o), 1);
    chk("rst_restart", 32'(bus.restart_o), 0);
    chk("rst_newlvl", 32'(bus.new_level_o), 0);
    reset_n = 1'b1;
    cycles(8);

    // Start latency: sampled at edge k, state changes at k+2.
    bus.start_btn_i = 1'b1;
    @(negedge clk);
    chk("start_k", 32'(bus.screen_o), 0);
    @(negedge clk);
    chk("start_k1", 32'(bus.screen_o), 0);
    @(negedge clk);
    chk("start_k2_screen", 32'(bus.screen_o), 1);
    chk("start_k2_restart", 32'(bus.restart_o), 1);
    chk("start_k2_newlvl", 32'(bus.new_level_o), 1);
    chk("start_lives", 32'(bus.lives_o), 3);
    chk("start_level", 32'(bus.level_o), 1);
    @(negedge clk);
    chk("start_restart_end", 32'(bus.restart_o), 0);
    chk("start_newlvl_end", 32'(bus.new_level_o), 0);
    cycles(6);
    chk("held_screen", 32'(bus.screen_o), 1);
    chk("held_restart", 32'(bus.restart_o), 0);
    bus.start_btn_i = 1'b0;
    cycles(3);

    // Gameplay events are ignored in READY.
    pulse_death();
    pulse_dots();
    cycles(2);
    chk("ready_ev_run", 32'(bus.game_run_o), 0);
    chk("ready_ev_lives", 32'(bus.lives_o), 3);
    chk("ready_ev_newlvl", 32'(bus.new_level_o), 0);
    ticks(119);
    chk("ready_119", 32'(bus.game_run_o), 0);
    ticks(1);
    chk("ready_120", 32'(bus.game_run_o), 1);
    chk("play_screen", 32'(bus.screen_o), 1);

`ifdef GAME_PAUSE_EN
    press();
    chk("pause_run", 32'(bus.game_run_o), 0);
    chk("pause_screen", 32'(bus.screen_o), 1);
    pulse_death();
    pulse_dots();
    ticks(5);
    chk("pause_lives", 32'(bus.lives_o), 3);
    chk("pause_run_hold", 32'(bus.game_run_o), 0);
    press();
    chk("resume_run", 32'(bus.game_run_o), 1);
    chk("resume_level", 32'(bus.level_o), 1);
`else
    press();
    chk("nopause_run", 32'(bus.game_run_o), 1);
`endif

    // Simultaneous death and clear: clear wins; level saturates at 15.
    for (int i = 0; i < 20; i++) begin
      int exp_lvl;
      exp_lvl = (i + 2 > 15) ? 15 : i + 2;
      bus.death_i        = 1'b1;
      bus.dots_cleared_i = 1'b1;
      @(negedge clk);
      bus.death_i        = 1'b0;
      bus.dots_cleared_i = 1'b0;
      chk("lvl_run_off", 32'(bus.game_run_o), 0);
      ticks(59);
      chk("lvl_59_newlvl", 32'(bus.new_level_o), 0);
      ticks(1);
      chk("lvl_level", 32'(bus.level_o), 32'(exp_lvl));
      chk("lvl_lives", 32'(bus.lives_o), 3);
      chk("lvl_newlvl", 32'(bus.new_level_o), 1);
      chk("lvl_restart", 32'(bus.restart_o), 1);
      ticks(120);
      chk("lvl_play", 32'(bus.game_run_o), 1);
    end

    // Three deaths: lives 2, 1, then game over without restart.
    for (int d = 0; d < 3; d++) begin
      pulse_death();
      chk("die_run", 32'(bus.game_run_o), 0);
      ticks(89);
      chk("die_89_lives", 32'(bus.lives_o), 32'(3 - d));
      chk("die_89_screen", 32'(bus.screen_o), 1);
      ticks(1);
      if (d < 2) begin
        chk("die_lives", 32'(bus.lives_o), 32'(2 - d));
        chk("die_restart", 32'(bus.restart_o), 1);
        chk("die_screen", 32'(bus.screen_o), 1);
        ticks(120);
        chk("die_replay", 32'(bus.game_run_o), 1);
      end else begin
        chk("over_lives", 32'(bus.lives_o), 0);
        chk("over_screen", 32'(bus.screen_o), 2);
        chk("over_restart", 32'(bus.restart_o), 0);
        @(negedge clk);
        chk("over_restart2", 32'(bus.restart_o), 0);
      end
    end

    // Game over hold: early press ignored, later press returns to title.
    ticks(100);
    press();
    chk("go_early", 32'(bus.screen_o), 2);
    ticks(100);
    chk("go_level_hold", 32'(bus.level_o), 15);
    press();
    chk("go_title", 32'(bus.screen_o), 0);
    chk("title_lives", 32'(bus.lives_o), 0);
    chk("title_level", 32'(bus.level_o), 15);

    // New game, then reset mid-game while a restart pulse is high.
    press();
    chk("ng_lives", 32'(bus.lives_o), 3);
    chk("ng_level", 32'(bus.level_o), 1);
    ticks(120);
    pulse_death();
    ticks(90);
    chk("ng_lives2", 32'(bus.lives_o), 2);
    ticks(120);
    pulse_dots();
    ticks(60);
    chk("ng_level2", 32'(bus.level_o), 2);
    chk("ng_restart", 32'(bus.restart_o), 1);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_screen", 32'(bus.screen_o), 0);
    chk("mid_rst_lives", 32'(bus.lives_o), 3);
    chk("mid_rst_level", 32'(bus.level_o), 1);
    chk("mid_rst_restart", 32'(bus.restart_o), 0);
    chk("mid_rst_newlvl", 32'(bus.new_level_o), 0);
    reset_n = 1'b1;
    cycles(2);
    press();
    chk("post_rst_start", 32'(bus.screen_o), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer for the Pacman design. It turns the player start button, per-frame timing ticks and gameplay events (death, maze cleared) into the screen select, movement enable, lives, level and restart controls. Its screen code drives the screen renderer mux. It replaces ad-hoc screen toggling with timed intermission states.

## Interface
- LIVES_INIT, 3: lives loaded at game start (1–7)
- MAX_LEVEL, 15: level saturation value (1–15)
- READY_FRAMES, 120: frames in READY before PLAY (1–255)
- DYING_FRAMES, 90: frames in DYING (1–255)
- LEVEL_FRAMES, 60: frames in LEVEL_DONE (1–255)
- GO_HOLD_FRAMES, 180: minimum frames in GAME_OVER before start is accepted (1–255)
- clk_i, in, 1: system clock (single domain)
- reset_ni, in, 1: reset, synchronous, active-low
- frame_tick_i, in, 1: one-cycle pulse per video frame
- start_btn_i, in, 1: raw asynchronous button level
- death_i, in, 1: one-cycle pulse, Pacman caught
- dots_cleared_i, in, 1: one-cycle pulse, last dot eaten
- screen_o, out, 2: 0 title, 1 maze, 2 game over; 3 never driven
- game_run_o, out, 1: actor movement enable
- lives_o, out, 3: remaining lives
- level_o, out, 4: current level, starting at 1
- restart_o, out, 1: one-cycle pulse to reset actors and maze
- new_level_o, out, 1: one-cycle pulse to refill dots

## Operation
- Start handling: two-flop synchronizer, then rising-edge detect giving `start_edge`. A held button yields one edge.
- Frame counter: 8 bits. Cleared on every state change. Increments on `frame_tick_i`. A timed state exits on the frame tick where count == N−1, so it lasts exactly N ticks.
- States, with their output decode:
  - TITLE: screen 0, run 0.
  - READY: screen 1, run 0.
  - PLAY: screen 1, run 1.
  - DYING: screen 1, run 0.
  - LEVEL_DONE: screen 1, run 0.
  - GAME_OVER: screen 2, run 0.
- TITLE → READY on `start_edge`:
  - lives := LIVES_INIT and level := 1.
  - restart_o and new_level_o pulse on the transition cycle.
- READY → PLAY after READY_FRAMES.
- PLAY exits:
  - On `dots_cleared_i` → LEVEL_DONE.
  - Otherwise on `death_i` → DYING.
  - If both arrive in the same cycle, dots_cleared_i wins and the death is dropped.
- DYING exit after DYING_FRAMES:
  - If lives == 1: lives := 0 and go to GAME_OVER.
  - Otherwise: lives −1, restart_o pulse, go to READY.
- LEVEL_DONE exit after LEVEL_FRAMES:
  - level := min(level+1, MAX_LEVEL).
  - restart_o and new_level_o pulse; go to READY.
  - Lives are unchanged.
- GAME_OVER → TITLE on `start_edge`, only once count ≥ GO_HOLD_FRAMES−1 has been reached. The counter saturates. Earlier edges are ignored. lives and level hold their last values.
- death_i and dots_cleared_i are ignored outside PLAY.
- `start_edge` is ignored in READY, DYING and LEVEL_DONE, and in PLAY unless PAUSE_EN is defined.

## Timing
- Reset (reset_ni low at a rising edge) forces the following on that edge, including mid-game; the frame counter and synchronizer flops are also cleared:
  - state TITLE
  - lives_o = LIVES_INIT, level_o = 1
  - screen_o = 0, game_run_o = 0
  - restart_o = 0, new_level_o = 0
- State, lives, level and pulses are registered. screen_o and game_run_o decode from the state register, so they change on the same edge as the state.
- Start latency: start_btn_i is first sampled high at edge k. The state changes at edge k+2. One press gives one transition.
- Event latency: a death_i or dots_cleared_i pulse sampled at edge k changes the state at edge k. The outputs reflect it in the following cycle.
- Pulse width: restart_o and new_level_o are high for exactly one cycle, the cycle after the transition edge.

## Configuration
- `GAME_PAUSE_EN` defined:
  - Adds a PAUSED state (screen 1, run 0). PLAY → PAUSED on `start_edge`, and PAUSED → PLAY on `start_edge`.
  - death_i and dots_cleared_i are ignored while PAUSED.
  - The frame counter is not used in PAUSED.
- `GAME_PAUSE_EN` undefined: no PAUSED state, and `start_edge` in PLAY has no effect.

## Structure
- Package `pacman_game_pkg` holds:
  - the state enum `game_state_t`, including PAUSED unconditionally;
  - screen code constants `SCREEN_TITLE`, `SCREEN_MAZE`, `SCREEN_OVER`;
  - the frame counter width constant.
- One sub-module, `start_btn_sync`: two-flop synchronizer plus edge detect, with the same clock and reset as the parent.

## Test plan
- Reset, then raise start_btn_i at edge 10 and hold it → state READY at edge 12. restart_o and new_level_o are each high for one cycle, lives_o = 3, level_o = 1, and there is no second transition while held.
- READY with 120 frame ticks → game_run_o rises after the 120th tick and not before.
- PLAY, 3 deaths, each followed by 90 ticks → lives go 2, 1, 0. The third death ends in screen_o = 2 with no restart_o pulse.
- PLAY with death_i and dots_cleared_i in the same cycle → LEVEL_DONE, lives unchanged, level_o = 2 after 60 ticks. Repeating 20 times saturates level_o at 15.
- GAME_OVER, press at tick 100 → ignored. Press at tick 200 → screen_o = 0.
- With `GAME_PAUSE_EN`: press in PLAY → run 0, and death_i while paused is ignored. A second press → run 1.
